muldiv_unit: RTL

Iterative, parametrised RV32M multiply/divide unit for the EX stage of the pipelined RV32IM core. It replaces single-cycle `*`, `/` and `%` datapaths with a shift-add multiplier and a restoring divider sharing one XLEN-cycle iteration engine. It uses a START/BUSY/DONE handshake so the hazard unit can stall the pipeline while an M-extension operation is in flight. Divide-by-zero and signed overflow follow the RISC-V specification and complete early.

---
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative M-extension unit.
// The EX stage drives the request side; the unit answers with BUSY, DONE and RESULT.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            START;
    logic [2:0]      OP;
    logic [XLEN-1:0] OPERAND_A;
    logic [XLEN-1:0] OPERAND_B;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    modport master (
        output START, OP, OPERAND_A, OPERAND_B,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, OP, OPERAND_A, OPERAND_B,
        output BUSY, DONE, RESULT
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiplier and restoring divider on magnitudes,
// sharing one XLEN-cycle engine; signs are re-applied when the result is registered.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    logic              neg_q, neg_d;
    logic              fast_q, fast_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            is_div_zero, is_overflow;
    logic [XLEN-1:0] fast_val;

    assign a_signed = (bus.OP == OP_MULH) || (bus.OP == OP_MULHSU) ||
                      (bus.OP == OP_DIV)  || (bus.OP == OP_REM);
    assign b_signed = (bus.OP == OP_MULH) || (bus.OP == OP_DIV) || (bus.OP == OP_REM);
    assign sign_a   = a_signed && bus.OPERAND_A[XLEN-1];
    assign sign_b   = b_signed && bus.OPERAND_B[XLEN-1];
    assign a_mag    = sign_a ? -bus.OPERAND_A : bus.OPERAND_A;
    assign b_mag    = sign_b ? -bus.OPERAND_B : bus.OPERAND_B;

    assign is_div_zero = bus.OP[2] && (bus.OPERAND_B == '0);
    assign is_overflow = ((bus.OP == OP_DIV) || (bus.OP == OP_REM)) &&
                         (bus.OPERAND_A == MIN_NEG) && (bus.OPERAND_B == '1);
    // op[1] separates the remainder flavours from the quotient flavours
    assign fast_val = is_div_zero ? (bus.OP[1] ? bus.OPERAND_A : '1)
                                  : (bus.OP[1] ? '0 : MIN_NEG);

    // Divide keeps the shifting dividend/quotient in the low half of work_q;
    // multiply keeps the product there with the multiplier draining out of bit 0.
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] addend;
    logic [XLEN:0]   mul_sum;

    assign trial   = {rem_q, work_q[XLEN-1]} - {1'b0, b_mag_q};
    assign addend  = work_q[0] ? b_mag_q : '0;
    assign mul_sum = {1'b0, work_q[2*XLEN-1:XLEN]} + {1'b0, addend};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    assign prod_fix = neg_q ? -work_q : work_q;
    assign quo_fix  = neg_q ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
    assign rem_fix  = neg_q ? -rem_q : rem_q;

    always_comb begin
        final_res = '0;
        if (fast_q) begin
            final_res = work_q[XLEN-1:0];
        end else begin
            case (op_q)
                OP_MUL:                       final_res = prod_fix[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:              final_res = quo_fix;
                OP_REM, OP_REMU:              final_res = rem_fix;
                default:                      final_res = '0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        rem_d    = rem_q;
        b_mag_d  = b_mag_q;
        neg_d    = neg_q;
        fast_d   = fast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    op_d    = bus.OP;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    b_mag_d = b_mag;
                    rem_d   = '0;
                    neg_d   = (bus.OP == OP_REM) ? sign_a : (sign_a ^ sign_b);
                    if (is_div_zero || is_overflow) begin
                        fast_d  = 1'b1;
                        work_d  = {{XLEN{1'b0}}, fast_val};
                        state_d = S_FINISH;
                    end else begin
                        fast_d  = 1'b0;
                        work_d  = {{XLEN{1'b0}}, a_mag};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[2]) begin
                    // restoring step: keep the subtraction only if it did not borrow
                    if (!trial[XLEN]) begin
                        rem_d  = trial[XLEN-1:0];
                        work_d = {work_q[2*XLEN-1:XLEN], work_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d  = {rem_q[XLEN-2:0], work_q[XLEN-1]};
                        work_d = {work_q[2*XLEN-1:XLEN], work_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    work_d = {mul_sum, work_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                result_d = final_res;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            work_q   <= '0;
            rem_q    <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            fast_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            b_mag_q  <= b_mag_d;
            neg_q    <= neg_d;
            fast_q   <= fast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;
endmodule
